// File: rtl/ram_loader_bridge.sv
// Main-memory bridge: a halfword image is streamed into a dual-port array while
// the core is held in reset, then the core gets a 1-cycle-latency RAM port.
module ram_loader_bridge #(
  parameter int unsigned DEPTH_HW = 8192,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic [15:0]      load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             load_done,
  output logic             load_error,
  output logic             core_reset_n,
  input  logic [31:0]      ram_rd_addr_in,
  output logic [15:0]      ram_rd_data_out,
  input  logic [31:0]      ram_wr_addr_in,
  input  logic [15:0]      ram_wr_data_in,
  input  logic             ram_wr_en_in,
  output logic             oob_flag
);
  localparam int unsigned IDX_W = $clog2(DEPTH_HW);

  typedef enum logic [1:0] {WAIT_LOAD, LOAD, DONE, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      mem [DEPTH_HW];

  logic [IDX_W-1:0] rd_idx, wr_idx, mem_idx;
  logic [15:0]      mem_din;
  logic             rd_ok, wr_ok, beat, last_beat, core_wr, mem_we, too_long;
  logic             unused_addr_lsbs;

  // Byte addresses: bit 0 selects nothing, in range iff no bits above IDX_W.
  assign rd_idx    = ram_rd_addr_in[IDX_W:1];
  assign wr_idx    = ram_wr_addr_in[IDX_W:1];
  assign rd_ok     = (ram_rd_addr_in >> (IDX_W + 1)) == 32'd0;
  assign wr_ok     = (ram_wr_addr_in >> (IDX_W + 1)) == 32'd0;
  assign unused_addr_lsbs = ram_rd_addr_in[0] ^ ram_wr_addr_in[0];

  assign beat      = load_valid && load_ready;
  assign last_beat = (32'(count) + 32'd1) == 32'(len_q);
  assign too_long  = 32'(load_len) > DEPTH_HW;
  assign core_wr   = (state == RUN) && ram_wr_en_in && wr_ok;

  // Loader and core never write in the same state, so one write port suffices.
  assign mem_we  = beat || core_wr;
  assign mem_idx = beat ? count : wr_idx;
  assign mem_din = beat ? load_data : ram_wr_data_in;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_LOAD;
      core_reset_n    <= 1'b0;
      load_ready      <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
      oob_flag        <= 1'b0;
      ram_rd_data_out <= '0;
      count           <= '0;
      len_q           <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        WAIT_LOAD: begin
          if (load_start) begin
            if (load_len == '0) begin
              state        <= RUN;
              core_reset_n <= 1'b1;
            end else if (too_long) begin
              load_error <= 1'b1;
            end else begin
              len_q      <= load_len;
              count      <= '0;
              state      <= LOAD;
              load_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            count <= count + IDX_W'(1);
            if (last_beat) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state        <= RUN;
          core_reset_n <= 1'b1;
        end
        RUN: ;
        default: state <= WAIT_LOAD;
      endcase

      if (state == RUN) begin
        if (!rd_ok) begin
          ram_rd_data_out <= '0;
          oob_flag        <= 1'b1;
        end else if (core_wr && (wr_idx == rd_idx)) begin
          ram_rd_data_out <= ram_wr_data_in;
        end else begin
          ram_rd_data_out <= mem[rd_idx];
        end
        if (ram_wr_en_in && !wr_ok) oob_flag <= 1'b1;
      end else begin
        ram_rd_data_out <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_loader_bridge.sv
// Directed bench for ram_loader_bridge: load sequences, core port, OOB, reset.
module tb_ram_loader_bridge;
  localparam int unsigned DEPTH_HW = 8192;

  logic        clk = 1'b0;
  logic        reset, load_start, load_valid, ram_wr_en_in;
  logic [15:0] load_len, load_data, ram_wr_data_in;
  logic [31:0] ram_rd_addr_in, ram_wr_addr_in;
  logic        load_ready, load_done, load_error, core_reset_n, oob_flag;
  logic [15:0] ram_rd_data_out;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  ram_loader_bridge #(.DEPTH_HW(DEPTH_HW), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .load_done(load_done), .load_error(load_error), .core_reset_n(core_reset_n),
    .ram_rd_addr_in(ram_rd_addr_in), .ram_rd_data_out(ram_rd_data_out),
    .ram_wr_addr_in(ram_wr_addr_in), .ram_wr_data_in(ram_wr_data_in),
    .ram_wr_en_in(ram_wr_en_in), .oob_flag(oob_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; ram_wr_en_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] len);
    load_start = 1'b1; load_len = len;
    tick();
    load_start = 1'b0;
  endtask

  // One beat with valid held; check load_done after the edge.
  task automatic beat(input logic [15:0] d, input logic exp_done);
    load_valid = 1'b1; load_data = d;
    tick();
    load_valid = 1'b0;
    check("load_done_after_beat", 32'(load_done), 32'(exp_done));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [15:0] exp);
    ram_rd_addr_in = addr;
    exp_q.push_back(exp);
    tick();
    check("rd_data", 32'(ram_rd_data_out), 32'(exp_q.pop_front()));
  endtask

  logic [15:0] img4 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] img3 [3] = '{16'h0A01, 16'h0A02, 16'h0A03};
  logic [15:0] img5 [5] = '{16'h5000, 16'h5001, 16'h5002, 16'h5003, 16'h5004};

  initial begin
    load_len = '0; load_data = '0; ram_rd_addr_in = '0;
    ram_wr_addr_in = '0; ram_wr_data_in = '0;
    do_reset();
    check("rst_core_reset_n", 32'(core_reset_n), 0);
    check("rst_load_ready", 32'(load_ready), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_error", 32'(load_error), 0);
    check("rst_oob", 32'(oob_flag), 0);
    check("rst_rd_data", 32'(ram_rd_data_out), 0);

    // 4-beat load, valid held high
    start_load(16'd4);
    check("t1_ready", 32'(load_ready), 1);
    for (int i = 0; i < 4; i++) beat(img4[i], i == 3);
    check("t1_held_in_done", 32'(core_reset_n), 0);
    check("t1_ready_done", 32'(load_ready), 0);
    tick();
    check("t1_release", 32'(core_reset_n), 1);
    check("t1_done_pulse", 32'(load_done), 0);
    for (int i = 0; i < 4; i++) do_read(32'(2 * i), img4[i]);

    // 3 beats with 2-cycle valid gaps
    do_reset();
    start_load(16'd3);
    for (int i = 0; i < 3; i++) begin
      beat(img3[i], i == 2);
      if (i < 2) begin
        tick(); tick();
        check("t2_no_early_done", 32'(load_done), 0);
        check("t2_ready_in_gap", 32'(load_ready), 1);
      end
    end
    tick();
    check("t2_release", 32'(core_reset_n), 1);
    for (int i = 0; i < 3; i++) do_read(32'(2 * i), img3[i]);
    do_read(32'd6, 16'h4444);

    // zero length, then over-length, then a valid 2-beat load
    do_reset();
    start_load(16'd0);
    check("t3_zero_run", 32'(core_reset_n), 1);
    check("t3_zero_no_done", 32'(load_done), 0);
    do_reset();
    start_load(16'(DEPTH_HW + 1));
    check("t3_err", 32'(load_error), 1);
    check("t3_err_held", 32'(core_reset_n), 0);
    check("t3_err_ready", 32'(load_ready), 0);
    tick();
    check("t3_err_sticky", 32'(load_error), 1);
    start_load(16'd2);
    beat(16'hA0A0, 1'b0);
    beat(16'hB0B0, 1'b1);
    tick();
    check("t3_release", 32'(core_reset_n), 1);
    do_read(32'd0, 16'hA0A0);
    do_read(32'd2, 16'hB0B0);

    // write-first forwarding and addr[0] ignored
    ram_wr_en_in = 1'b1; ram_wr_addr_in = 32'h10; ram_wr_data_in = 16'hBEEF;
    do_read(32'h10, 16'hBEEF);
    ram_wr_en_in = 1'b0;
    do_read(32'h11, 16'hBEEF);
    check("t4_oob_clear", 32'(oob_flag), 0);

    // out-of-range write dropped, out-of-range read returns 0
    ram_wr_en_in = 1'b1; ram_wr_addr_in = 32'(2 * DEPTH_HW); ram_wr_data_in = 16'hDEAD;
    tick();
    ram_wr_en_in = 1'b0;
    check("t5_oob_wr", 32'(oob_flag), 1);
    do_read(32'(2 * DEPTH_HW), 16'h0000);
    do_read(32'd0, 16'hA0A0);
    check("t5_oob_sticky", 32'(oob_flag), 1);

    // reset mid-load, then fresh 5-beat load
    do_reset();
    start_load(16'd5);
    beat(16'h0101, 1'b0);
    beat(16'h0202, 1'b0);
    do_reset();
    check("t6_held", 32'(core_reset_n), 0);
    check("t6_ready", 32'(load_ready), 0);
    check("t6_oob_cleared", 32'(oob_flag), 0);
    start_load(16'd5);
    for (int i = 0; i < 5; i++) beat(img5[i], i == 4);
    tick();
    check("t6_release", 32'(core_reset_n), 1);
    for (int i = 0; i < 5; i++) do_read(32'(2 * i), img5[i]);

    // out-of-range read alone sets the flag; array survives reset
    do_reset();
    start_load(16'd0);
    do_read(32'd0, 16'h5000);
    check("t7_oob_before", 32'(oob_flag), 0);
    do_read(32'(2 * DEPTH_HW + 2), 16'h0000);
    check("t7_oob_rd", 32'(oob_flag), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
